rom_arbiter: RTL and testbench
==============================

# rom_arbiter

Arbitrates one synchronous single-port sprite/graphics ROM between two requesters: the picture processing unit (pixel fetches, hard real-time during active video) and the game statemachine (attribute/hitbox lookups). It sits between `ppu`, `statemachine` and the ROM inside `console`, on the 108 MHz PLL clock. It issues at most one ROM read per cycle, tags each read with its owner, and routes returned data back in order. An optional starvation guard bounds statemachine wait time during active video.

## Interface
- `ADDR_W`, 14, ROM address width
- `DATA_W`, 16, ROM data width
- `ROM_LAT`, 2, ROM read latency in cycles from `rom_rd` sample to valid `rom_q` (1..4)
- `STARVE_MAX`, 8, statemachine wait cycles tolerated before a forced grant (guard build only; 1..255)

- `clock` in 1: single clock; everything on the rising edge
- `reset` in 1: synchronous, active-high
- `blank` in 1: 1 = display outside active area (hsync/vsync blanking)
- `ppu_req` in 1, `ppu_addr` in ADDR_W: PPU read request and address
- `ppu_ack` out 1: request accepted this cycle
- `ppu_valid` out 1, `ppu_data` out DATA_W: returned data strobe and data
- `sm_req` in 1, `sm_addr` in ADDR_W, `sm_ack` out 1, `sm_valid` out 1, `sm_data` out DATA_W: same for statemachine
- `rom_rd` out 1, `rom_addr` out ADDR_W: ROM read strobe and address
- `rom_q` in DATA_W: ROM read data

## Operation
- Handshake: requester holds `req` high and `addr` stable until it sees `ack`; `ack` is combinational from the current `req`/`blank`/counter state, at most one of `ppu_ack`/`sm_ack` high per cycle. Requester may keep `req` high after `ack` to issue back-to-back reads (one per cycle).
- Grant rule per cycle:
  - only one `req` high: grant it.
  - both high, `blank`=0: grant PPU, unless guard is built and `starve_cnt` == STARVE_MAX, then grant SM.
  - both high, `blank`=1: grant SM.
  - neither: no grant, `rom_rd`=0.
- `starve_cnt` (8 bit, guard build only): +1 each cycle `sm_req`=1 and `sm_ack`=0, saturating at STARVE_MAX; cleared to 0 on `sm_ack` or when `sm_req`=0.
- Tag pipeline: ROM_LAT+1 stages of {valid, owner}; stage 0 loaded with the grant, shifts every cycle unconditionally (no backpressure; requesters must always accept data).
- At pipeline output: `rom_q` registered into owner's `*_data`, owner's `*_valid` pulses one cycle. Non-owner data register holds its previous value.
- Data returns strictly in grant order; ownership never swaps mid-flight.

## Timing
- Grant in cycle N (`ack`=1) -> `rom_rd`=1, `rom_addr`=granted address in cycle N+1 (registered) -> `rom_q` valid in N+1+ROM_LAT -> `*_valid`=1 and `*_data` updated in N+2+ROM_LAT. Total latency ack-to-valid = ROM_LAT+2 cycles (4 at default).
- Throughput: one read per cycle sustained, any mix of owners.
- Reset values: `ppu_ack`=`sm_ack`=0 (while `reset`=1, acks forced 0 regardless of `req`), `ppu_valid`=`sm_valid`=0, `ppu_data`=`sm_data`=0, `rom_rd`=0, `rom_addr`=0, `starve_cnt`=0, all tag stages invalid.
- Reset mid-operation: all in-flight reads discarded; no `*_valid` pulse for any read granted before reset, even if `rom_q` arrives after reset deasserts.
- `blank` change takes effect on the grant in the same cycle; in-flight reads unaffected.

## Configuration
- `ROM_ARB_STARVE_GUARD_EN` defined: starvation counter built; during active video SM is granted once after waiting STARVE_MAX cycles, then PPU priority resumes.
- Not defined: no counter; strict PPU priority while `blank`=0 (SM may wait indefinitely); `STARVE_MAX` unused.

## Test plan
- Reset, then `ppu_req`=1 `ppu_addr`=0x0010 single cycle, ROM model returns 0xA5A5 -> `ppu_ack` cycle 0, `rom_rd`/`rom_addr`=0x0010 cycle 1, `ppu_valid`=1 `ppu_data`=0xA5A5 cycle 4; `sm_valid` stays 0.
- Both req held, `blank`=0, guard built, STARVE_MAX=8 -> 8 PPU acks, 9th cycle `sm_ack`, then PPU resumes; guard not built -> zero `sm_ack` over 100 cycles.
- Both req held, `blank`=1 -> `sm_ack` every cycle, PPU none; drop `blank` -> PPU wins next cycle.
- Alternating PPU/SM back-to-back grants, addresses 0..7 -> valids return in same order, each data matches address, one valid per cycle, no gaps.
- Grant PPU read, assert `reset` for 1 cycle at N+2 -> no `ppu_valid` ever for that read; all outputs 0 during and after reset until a new grant.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if
//   Bundles every handshake and data signal around the sprite ROM arbiter:
//   the PPU request/return port, the statemachine request/return port, the
//   display blanking flag and the single-port ROM read bus.
//
//   Ports of the interface (all single clock domain, owned by the user):
//     blank                     1 = display outside active area
//     ppu_req / ppu_addr        PPU read request and address
//     ppu_ack                   PPU request accepted this cycle
//     ppu_valid / ppu_data      PPU returned-data strobe and data
//     sm_req / sm_addr          statemachine read request and address
//     sm_ack                    statemachine request accepted this cycle
//     sm_valid / sm_data        statemachine returned-data strobe and data
//     rom_rd / rom_addr         ROM read strobe and address
//     rom_q                     ROM read data
//
//   Modports:
//     slave  - the arbiter's view
//     master - the surrounding system (requesters and ROM)
interface rom_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic              blank;

    logic              ppu_req;
    logic [ADDR_W-1:0] ppu_addr;
    logic              ppu_ack;
    logic              ppu_valid;
    logic [DATA_W-1:0] ppu_data;

    logic              sm_req;
    logic [ADDR_W-1:0] sm_addr;
    logic              sm_ack;
    logic              sm_valid;
    logic [DATA_W-1:0] sm_data;

    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_q;

    modport slave (
        input  blank,
        input  ppu_req, ppu_addr,
        output ppu_ack, ppu_valid, ppu_data,
        input  sm_req, sm_addr,
        output sm_ack, sm_valid, sm_data,
        output rom_rd, rom_addr,
        input  rom_q
    );

    modport master (
        output blank,
        output ppu_req, ppu_addr,
        input  ppu_ack, ppu_valid, ppu_data,
        output sm_req, sm_addr,
        input  sm_ack, sm_valid, sm_data,
        input  rom_rd, rom_addr,
        output rom_q
    );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter
//   Shares one synchronous single-port sprite/graphics ROM between the picture
//   processing unit (hard real-time pixel fetches) and the game statemachine
//   (attribute/hitbox lookups). At most one ROM read is issued per cycle; each
//   read carries an owner tag through a pipeline that matches the ROM latency,
//   so returned data is steered back to its requester strictly in grant order.
//
//   Optional feature macro: ROM_ARB_STARVE_GUARD_EN
//     defined     - an 8-bit starvation counter forces one statemachine grant
//                   after it has waited STARVE_MAX cycles during active video
//     not defined - strict PPU priority while blank = 0
//
//   Parameters:
//     ADDR_W      ROM address width
//     DATA_W      ROM data width
//     ROM_LAT     cycles from rom_rd sample to valid rom_q (1..4)
//     STARVE_MAX  statemachine wait cycles before a forced grant (1..255)
//
//   Ports:
//     clock       single clock, rising edge
//     reset       synchronous, active-high
//     bus         rom_arbiter_if.slave (requester ports, blank, ROM bus)
//
//   Timing: ack in cycle N -> rom_rd/rom_addr in N+1 -> rom_q in N+1+ROM_LAT
//           -> *_valid/*_data in N+2+ROM_LAT.
module rom_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 16,
    parameter int ROM_LAT    = 2,
    parameter int STARVE_MAX = 8
) (
    input logic          clock,
    input logic          reset,
    rom_arbiter_if.slave bus
);

    if (ROM_LAT < 1 || ROM_LAT > 4) begin : g_bad_rom_lat
        $error("rom_arbiter: ROM_LAT must be in 1..4");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_starve_max
        $error("rom_arbiter: STARVE_MAX must be in 1..255");
    end

    // Grant decision (combinational, same cycle as the request)
    logic ppu_gnt;
    logic sm_gnt;
    logic force_sm;

`ifdef ROM_ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starve_cnt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] lim);
        return (v >= lim) ? lim : v + 8'd1;
    endfunction

    // The counter only runs while the statemachine is actively waiting; any
    // grant to it or a dropped request restarts the wait from zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= 8'd0;
        end else if (!bus.sm_req || sm_gnt) begin
            starve_cnt <= 8'd0;
        end else begin
            starve_cnt <= sat_inc(starve_cnt, STARVE_LIM);
        end
    end

    assign force_sm = (starve_cnt == STARVE_LIM);
`else
    assign force_sm = 1'b0;
`endif

    always_comb begin
        ppu_gnt = 1'b0;
        sm_gnt  = 1'b0;
        // Acks are held low for the whole reset cycle so nothing is accepted
        // that the pipeline flush would then silently drop.
        if (!reset) begin
            if (bus.ppu_req && bus.sm_req) begin
                if (bus.blank || force_sm) begin
                    sm_gnt = 1'b1;
                end else begin
                    ppu_gnt = 1'b1;
                end
            end else begin
                ppu_gnt = bus.ppu_req;
                sm_gnt  = bus.sm_req;
            end
        end
    end

    assign bus.ppu_ack = ppu_gnt;
    assign bus.sm_ack  = sm_gnt;

    // Stage p0: registered ROM command plus the head of the tag pipeline.
    // vld_p[k] / own_p[k] describe the read issued k cycles ago; own = 1 means
    // the statemachine owns it. vld_p[0] doubles as the ROM read strobe.
    logic [ROM_LAT:0]  vld_p;
    logic [ROM_LAT:0]  own_p;
    logic [ADDR_W-1:0] addr_p0;

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p[0] <= 1'b0;
            own_p[0] <= 1'b0;
            addr_p0  <= '0;
        end else begin
            vld_p[0] <= ppu_gnt | sm_gnt;
            own_p[0] <= sm_gnt;
            // Address holds its last value on idle cycles.
            if (ppu_gnt) begin
                addr_p0 <= bus.ppu_addr;
            end else if (sm_gnt) begin
                addr_p0 <= bus.sm_addr;
            end
        end
    end

    assign bus.rom_rd   = vld_p[0];
    assign bus.rom_addr = addr_p0;

    // Stages p1..pROM_LAT: tags shift unconditionally in lockstep with the ROM
    // latency; clearing them on reset discards every read still in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p[ROM_LAT:1] <= '0;
            own_p[ROM_LAT:1] <= '0;
        end else begin
            for (int k = 1; k <= ROM_LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
                own_p[k] <= own_p[k-1];
            end
        end
    end

    // Output stage: rom_q is valid exactly when the oldest tag reaches the end
    // of the pipeline; only the owner's data register loads, the other holds.
    logic              ppu_vld_out;
    logic              sm_vld_out;
    logic [DATA_W-1:0] ppu_data_out;
    logic [DATA_W-1:0] sm_data_out;
    logic              ret_ppu;
    logic              ret_sm;

    assign ret_ppu = vld_p[ROM_LAT] & ~own_p[ROM_LAT];
    assign ret_sm  = vld_p[ROM_LAT] &  own_p[ROM_LAT];

    always_ff @(posedge clock) begin
        if (reset) begin
            ppu_vld_out  <= 1'b0;
            sm_vld_out   <= 1'b0;
            ppu_data_out <= '0;
            sm_data_out  <= '0;
        end else begin
            ppu_vld_out <= ret_ppu;
            sm_vld_out  <= ret_sm;
            if (ret_ppu) begin
                ppu_data_out <= bus.rom_q;
            end
            if (ret_sm) begin
                sm_data_out <= bus.rom_q;
            end
        end
    end

    assign bus.ppu_valid = ppu_vld_out;
    assign bus.ppu_data  = ppu_data_out;
    assign bus.sm_valid  = sm_vld_out;
    assign bus.sm_data   = sm_data_out;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter
//   Table-driven bench for rom_arbiter with a latency-accurate ROM model and a
//   scoreboard queue of expected returns (owner, data, due cycle). Expected
//   acks come from the vector table or from the hand-written sequences; the
//   ROM command, valids and both data registers are compared every cycle.
module tb_rom_arbiter;
    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 16;
    localparam int ROM_LAT    = 2;
    localparam int STARVE_MAX = 8;

    logic clock;
    logic reset;

    rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rom_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .ROM_LAT   (ROM_LAT),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM contents: 0x0010 holds 0xA5A5, every other word is derived from its address.
    function automatic logic [DATA_W-1:0] rom_val(input logic [ADDR_W-1:0] a);
        if (a == 14'h0010) return 16'hA5A5;
        return DATA_W'(a) ^ 16'h3C00;
    endfunction

    // ROM model: ROM_LAT registers from rom_addr to rom_q.
    logic [DATA_W-1:0] q_pipe [ROM_LAT];
    always @(posedge clock) begin
        q_pipe[0] <= rom_val(bus.rom_addr);
        for (int k = 1; k < ROM_LAT; k++) q_pipe[k] <= q_pipe[k-1];
    end
    assign bus.rom_q = q_pipe[ROM_LAT-1];

    typedef struct {
        logic              own_sm;
        logic [DATA_W-1:0] data;
        int                due;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic              blank;
        logic              pr;
        logic [ADDR_W-1:0] pa;
        logic              sr;
        logic [ADDR_W-1:0] sa;
        logic              ep;
        logic              es;
    } vec_t;
    localparam int NV = 19;
    vec_t vecs [NV];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic              exp_rd, nxt_rd;
    logic [ADDR_W-1:0] exp_addr, nxt_addr;
    logic [DATA_W-1:0] exp_pd, exp_sd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic monitor();
        logic ev_p, ev_s;
        sb_t  e;
        ev_p = 1'b0;
        ev_s = 1'b0;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            if (e.own_sm) begin ev_s = 1'b1; exp_sd = e.data; end
            else          begin ev_p = 1'b1; exp_pd = e.data; end
        end
        check("rom_rd",    bus.rom_rd,    exp_rd);
        check("rom_addr",  bus.rom_addr,  exp_addr);
        check("ppu_valid", bus.ppu_valid, ev_p);
        check("sm_valid",  bus.sm_valid,  ev_s);
        check("ppu_data",  bus.ppu_data,  exp_pd);
        check("sm_data",   bus.sm_data,   exp_sd);
    endtask

    task automatic tick();
        logic was_rst;
        was_rst = reset;
        @(posedge clock);
        #1;
        cyc++;
        if (was_rst) begin
            sbq.delete();
            exp_rd   = 1'b0;
            exp_addr = '0;
            exp_pd   = '0;
            exp_sd   = '0;
        end else begin
            exp_rd = nxt_rd;
            if (nxt_rd) exp_addr = nxt_addr;
        end
        monitor();
    endtask

    task automatic drive(input string name, input logic b, input logic pr,
                         input logic [ADDR_W-1:0] pa, input logic sr,
                         input logic [ADDR_W-1:0] sa, input logic ep, input logic es);
        bus.blank    = b;
        bus.ppu_req  = pr;
        bus.ppu_addr = pa;
        bus.sm_req   = sr;
        bus.sm_addr  = sa;
        #2;
        check({name, " ppu_ack"}, bus.ppu_ack, ep);
        check({name, " sm_ack"},  bus.sm_ack,  es);
        nxt_rd = 1'b0;
        if (ep) begin
            sbq.push_back('{1'b0, rom_val(pa), cyc + ROM_LAT + 2});
            nxt_rd = 1'b1; nxt_addr = pa;
        end else if (es) begin
            sbq.push_back('{1'b1, rom_val(sa), cyc + ROM_LAT + 2});
            nxt_rd = 1'b1; nxt_addr = sa;
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive("idle", 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        int sm_n;
        logic es;

        vecs[0]  = '{1'b0, 1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 14'h010, 1'b0, 14'h000, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 14'h000, 1'b0, 14'h000, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 14'h000, 1'b1, 14'h021, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 14'h022, 1'b1, 14'h023, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 14'h022, 1'b1, 14'h024, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 14'h000, 1'b1, 14'h024, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 14'h025, 1'b0, 14'h000, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) vecs[11+i] = '{1'b0, 1'b1, ADDR_W'(i), 1'b0, 14'h000, 1'b1, 1'b0};
            else            vecs[11+i] = '{1'b0, 1'b0, 14'h000, 1'b1, ADDR_W'(i), 1'b0, 1'b1};
        end

        exp_rd = 1'b0; nxt_rd = 1'b0;
        exp_addr = '0; nxt_addr = '0;
        exp_pd = '0;   exp_sd = '0;

        // Reset with both requests high: acks must stay low.
        reset = 1'b1;
        drive("reset", 1'b0, 1'b1, 14'h005, 1'b1, 14'h006, 1'b0, 1'b0);
        drive("reset", 1'b0, 1'b1, 14'h005, 1'b1, 14'h006, 1'b0, 1'b0);
        reset = 1'b0;

        // Vector table: single grants, priority cases, alternating owners 0..7.
        for (int i = 0; i < NV; i++)
            drive($sformatf("vec%0d", i), vecs[i].blank, vecs[i].pr, vecs[i].pa,
                  vecs[i].sr, vecs[i].sa, vecs[i].ep, vecs[i].es);
        idle(ROM_LAT + 3);

        // Both requesters held during active video.
`ifdef ROM_ARB_STARVE_GUARD_EN
        n = 3 * (STARVE_MAX + 1);
`else
        n = 100;
`endif
        sm_n = 0;
        for (int i = 0; i < n; i++) begin
`ifdef ROM_ARB_STARVE_GUARD_EN
            es = ((i % (STARVE_MAX + 1)) == STARVE_MAX);
`else
            es = 1'b0;
`endif
            drive("starve", 1'b0, 1'b1, ADDR_W'(14'h100 + i), 1'b1,
                  ADDR_W'(14'h200 + sm_n), ~es, es);
            if (es) sm_n++;
        end
        idle(ROM_LAT + 3);

        // Blanking: SM wins every cycle, PPU resumes as soon as blank drops.
        for (int i = 0; i < 5; i++)
            drive("blank_hi", 1'b1, 1'b1, 14'h300, 1'b1, ADDR_W'(14'h380 + i), 1'b0, 1'b1);
        drive("blank_drop", 1'b0, 1'b1, 14'h300, 1'b1, 14'h390, 1'b1, 1'b0);
        idle(ROM_LAT + 3);

        // Reset while a PPU read is in flight: the read must never return.
        drive("rst_grant", 1'b0, 1'b1, 14'h033, 1'b0, '0, 1'b1, 1'b0);
        idle(1);
        reset = 1'b1;
        drive("rst_mid", 1'b0, 1'b1, 14'h044, 1'b1, 14'h045, 1'b0, 1'b0);
        reset = 1'b0;
        idle(ROM_LAT + 4);
        drive("post_rst", 1'b0, 1'b1, 14'h010, 1'b0, '0, 1'b1, 1'b0);
        idle(ROM_LAT + 4);

        check("drain", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
